frame_rx: RTL and testbench

FRAME_RX -- requirements
Module: frame_rx

---
 rtl/frame_rx_pkg.sv | 29 ++
 rtl/frame_rx_bit_sampler.sv | 61 ++++++
 rtl/frame_rx.sv | 244 ++++++++++++++++++++++++
 tb/tb_frame_rx.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_rx_pkg.sv
// -----------------------------------------------------------------------------
// frame_rx_pkg
// Shared UART constants and the frame receiver state encoding. The 8N1 data
// bit count and the oversample counter sizing are shared with the transmitter
// side, so they live here rather than in either block.
// -----------------------------------------------------------------------------
package frame_rx_pkg;

    // 8N1 framing: 8 data bits, LSB first.
    localparam int UART_DATA_BITS = 8;

    // Largest supported oversampling ratio; counters are sized for it.
    localparam int UART_MAX_OVS   = 16;
    localparam int UART_OVS_CNT_W = $clog2(UART_MAX_OVS);

    // Bit counter must hold 0..UART_DATA_BITS.
    localparam int UART_BIT_CNT_W = $clog2(UART_DATA_BITS + 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_GAP   = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } rx_state_e;

endpackage

// File: rtl/frame_rx_bit_sampler.sv
// -----------------------------------------------------------------------------
// frame_rx_bit_sampler
// Two-flop synchroniser for the serial line plus the oversample counter that
// produces the mid-bit sample strobe.
//
// Ports:
//   clk_i       oversampling clock
//   reset_i     asynchronous active-high reset
//   rx_i        raw serial line (asynchronous to clk_i)
//   run_i       counter runs while high; held at 0 while low
//   half_i      1: strobe after OVS/2 clocks (start bit), 0: after OVS clocks
//   rx_sync_o   synchronised serial line
//   sample_o    one-clock strobe at the sampling point
// -----------------------------------------------------------------------------
module frame_rx_bit_sampler
    import frame_rx_pkg::*;
#(
    parameter int OVS = 8
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic rx_i,
    input  logic run_i,
    input  logic half_i,
    output logic rx_sync_o,
    output logic sample_o
);

    localparam logic [UART_OVS_CNT_W-1:0] HALF_LAST = UART_OVS_CNT_W'(OVS / 2 - 1);
    localparam logic [UART_OVS_CNT_W-1:0] FULL_LAST = UART_OVS_CNT_W'(OVS - 1);

    logic                      rx_meta_q;
    logic                      rx_sync_q;
    logic [UART_OVS_CNT_W-1:0] cnt_q;
    logic [UART_OVS_CNT_W-1:0] cnt_d;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            cnt_q     <= '0;
        end else begin
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
            cnt_q     <= cnt_d;
        end
    end

    assign sample_o  = run_i && (cnt_q == (half_i ? HALF_LAST : FULL_LAST));
    assign rx_sync_o = rx_sync_q;

    // Restart after every strobe so the next bit is measured from this sample
    // point; idle states keep the counter at zero for the next start bit.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (!run_i || sample_o) begin
            cnt_d = '0;
        end
    end

endmodule

// File: rtl/frame_rx.sv
// -----------------------------------------------------------------------------
// frame_rx
// RS485 frame receiver: collects BYTES 8N1 bytes into a frame and writes each
// byte to a buffer at {0, cycle, byte_idx}. Reports a clean frame with
// frame_done and a framing error or inter-byte timeout with frame_err.
//
// Ports:
//   clk_i         oversampling clock (OVS x baud)
//   reset_i       asynchronous active-high reset
//   en_i          receiver enable; low forces IDLE and drops a partial frame
//   rx_i          serial line, idle high
//   cycle_i       frame slot index, latched at the start bit of byte 0
//   wr_addr_o     write address {1'b0, cycle, byte_idx[1:0]}
//   wr_data_o     received byte
//   wr_en_o       one-clock write strobe
//   frame_done_o  one-clock pulse after the last byte of a clean frame
//   frame_err_o   one-clock pulse on framing error or inter-byte timeout
//   busy_o        high whenever the FSM is not in IDLE
//   state_o       current FSM state (rx_state_e encoding)
// -----------------------------------------------------------------------------
module frame_rx
    import frame_rx_pkg::*;
#(
    parameter int BYTES    = 4,
    parameter int OVS      = 8,
    parameter int GAP_BITS = 4
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       en_i,
    input  logic       rx_i,
    input  logic [5:0] cycle_i,
    output logic [8:0] wr_addr_o,
    output logic [7:0] wr_data_o,
    output logic       wr_en_o,
    output logic       frame_done_o,
    output logic       frame_err_o,
    output logic       busy_o,
    output logic [2:0] state_o
);

    localparam int GAP_CLKS = GAP_BITS * OVS;
    localparam int GAP_W    = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;

    localparam logic [GAP_W-1:0]          GAP_LAST  = GAP_W'(GAP_CLKS - 1);
    localparam logic [UART_OVS_CNT_W-1:0] HI_LAST   = UART_OVS_CNT_W'(OVS - 1);
    localparam logic [UART_BIT_CNT_W-1:0] BIT_LAST  = UART_BIT_CNT_W'(UART_DATA_BITS - 1);
    localparam logic [2:0]                BYTE_LAST = 3'(BYTES - 1);

    rx_state_e                 state_q, state_d;
    logic [UART_BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [2:0]                byte_idx_q, byte_idx_d;
    logic [7:0]                shift_q, shift_d;
    logic [5:0]                cycle_q, cycle_d;
    logic [GAP_W-1:0]          gap_cnt_q, gap_cnt_d;
    logic [UART_OVS_CNT_W-1:0] hi_cnt_q, hi_cnt_d;
    logic [8:0]                wr_addr_q, wr_addr_d;
    logic [7:0]                wr_data_q, wr_data_d;
    logic                      wr_en_q, wr_en_d;
    logic                      frame_done_q, frame_done_d;
    logic                      frame_err_q, frame_err_d;

    logic rx_s;
    logic sample;
    logic run;
    logic half;

    // The oversample counter only runs while a bit is being timed.
    assign run  = (state_q == ST_START) || (state_q == ST_DATA) || (state_q == ST_STOP);
    assign half = (state_q == ST_START);

    frame_rx_bit_sampler #(
        .OVS (OVS)
    ) u_sampler (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .rx_i      (rx_i),
        .run_i     (run),
        .half_i    (half),
        .rx_sync_o (rx_s),
        .sample_o  (sample)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            byte_idx_q   <= '0;
            shift_q      <= '0;
            cycle_q      <= '0;
            gap_cnt_q    <= '0;
            hi_cnt_q     <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            wr_en_q      <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_idx_q   <= byte_idx_d;
            shift_q      <= shift_d;
            cycle_q      <= cycle_d;
            gap_cnt_q    <= gap_cnt_d;
            hi_cnt_q     <= hi_cnt_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            wr_en_q      <= wr_en_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // Strobes are registered: a transition decided in this clock shows its
    // pulse in the next one. The write therefore lands in the first GAP/DONE
    // clock and frame_done in the clock after DONE, so the three pulses can
    // never coincide.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        byte_idx_d   = byte_idx_q;
        shift_d      = shift_q;
        cycle_d      = cycle_q;
        gap_cnt_d    = gap_cnt_q;
        hi_cnt_d     = hi_cnt_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        wr_en_d      = 1'b0;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;

        if (!en_i) begin
            state_d    = ST_IDLE;
            byte_idx_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state_d    = ST_START;
                        bit_cnt_d  = '0;
                        byte_idx_d = '0;
                        cycle_d    = cycle_i;
                    end
                end

                ST_START: begin
                    if (sample) begin
                        if (!rx_s) begin
                            state_d   = ST_DATA;
                            bit_cnt_d = '0;
                        end else if (byte_idx_q == 3'd0) begin
                            // Glitch before the first byte: nothing to abandon.
                            state_d = ST_IDLE;
                        end else begin
                            // Glitch between bytes: keep waiting for the real start.
                            state_d   = ST_GAP;
                            gap_cnt_d = '0;
                        end
                    end
                end

                ST_DATA: begin
                    if (sample) begin
                        shift_d   = {rx_s, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == BIT_LAST) begin
                            state_d = ST_STOP;
                        end
                    end
                end

                ST_STOP: begin
                    if (sample) begin
                        if (rx_s) begin
                            wr_en_d    = 1'b1;
                            wr_data_d  = shift_q;
                            wr_addr_d  = {1'b0, cycle_q, byte_idx_q[1:0]};
                            byte_idx_d = byte_idx_q + 3'd1;
                            if (byte_idx_q == BYTE_LAST) begin
                                state_d = ST_DONE;
                            end else begin
                                state_d   = ST_GAP;
                                gap_cnt_d = '0;
                            end
                        end else begin
                            state_d     = ST_ERR;
                            frame_err_d = 1'b1;
                            byte_idx_d  = '0;
                            hi_cnt_d    = '0;
                        end
                    end
                end

                ST_GAP: begin
                    if (!rx_s) begin
                        state_d   = ST_START;
                        bit_cnt_d = '0;
                    end else if (gap_cnt_q == GAP_LAST) begin
                        state_d     = ST_ERR;
                        frame_err_d = 1'b1;
                        byte_idx_d  = '0;
                        hi_cnt_d    = '0;
                    end else begin
                        gap_cnt_d = gap_cnt_q + 1'b1;
                    end
                end

                ST_DONE: begin
                    frame_done_d = 1'b1;
                    byte_idx_d   = '0;
                    state_d      = ST_IDLE;
                end

                ST_ERR: begin
                    // Resynchronise: require one full bit-time of idle line so a
                    // new start bit is not mistaken inside the broken byte.
                    if (rx_s) begin
                        if (hi_cnt_q == HI_LAST) begin
                            state_d = ST_IDLE;
                        end else begin
                            hi_cnt_d = hi_cnt_q + 1'b1;
                        end
                    end else begin
                        hi_cnt_d = '0;
                    end
                end

                default: begin
                    state_d    = ST_IDLE;
                    byte_idx_d = '0;
                end
            endcase
        end
    end

    assign wr_addr_o    = wr_addr_q;
    assign wr_data_o    = wr_data_q;
    assign wr_en_o      = wr_en_q;
    assign frame_done_o = frame_done_q;
    assign frame_err_o  = frame_err_q;
    assign busy_o       = (state_q != ST_IDLE);
    assign state_o      = state_q;

endmodule

// File: tb/tb_frame_rx.sv
// -----------------------------------------------------------------------------
// tb_frame_rx
// Directed bench for frame_rx with OVS=8, BYTES=4, GAP_BITS=4. A monitor logs
// every write strobe and pulse; the directed sequence compares the log against
// hand-computed expected writes and pulse counts after each step.
// -----------------------------------------------------------------------------
module tb_frame_rx;
    import frame_rx_pkg::*;

    localparam int OVS = 8;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       rx;
    logic [5:0] cycle;
    logic [8:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_en;
    logic       frame_done;
    logic       frame_err;
    logic       busy;
    logic [2:0] state;

    always #5 clk = ~clk;

    frame_rx #(
        .BYTES    (4),
        .OVS      (OVS),
        .GAP_BITS (4)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .en_i         (en),
        .rx_i         (rx),
        .cycle_i      (cycle),
        .wr_addr_o    (wr_addr),
        .wr_data_o    (wr_data),
        .wr_en_o      (wr_en),
        .frame_done_o (frame_done),
        .frame_err_o  (frame_err),
        .busy_o       (busy),
        .state_o      (state)
    );

    // ---------------- scoreboard ----------------
    logic [16:0] exp_q[$];
    logic [16:0] got_q[$];
    int checks      = 0;
    int failures    = 0;
    int cyc         = 0;
    int done_cnt    = 0;
    int err_cnt     = 0;
    int overlap_cnt = 0;
    int last_wr_cyc   = 0;
    int last_done_cyc = 0;
    int last_err_cyc  = 0;
    int done_base;
    int err_base;

    always @(posedge clk) cyc++;

    // Observe outputs on the falling edge, well away from the active edge.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            got_q.push_back({wr_addr, wr_data});
            last_wr_cyc = cyc;
        end
        if (frame_done === 1'b1) begin
            done_cnt++;
            last_done_cyc = cyc;
        end
        if (frame_err === 1'b1) begin
            err_cnt++;
            last_err_cyc = cyc;
        end
        if ($countones({wr_en === 1'b1, frame_done === 1'b1, frame_err === 1'b1}) > 1)
            overlap_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_writes(input string tag);
        logic [16:0] e;
        logic [16:0] g;
        chk({tag, "_wr_count"}, got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            chk({tag, "_wr"}, {15'd0, g}, {15'd0, e});
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic step_begin();
        got_q.delete();
        exp_q.delete();
        done_base = done_cnt;
        err_base  = err_cnt;
    endtask

    // ---------------- driver tasks ----------------
    // Called right after a rising edge (+1). Sends start, nbits data bits and,
    // for a full byte, the stop bit. alt stretches odd-indexed bit periods to
    // OVS+1 clocks to model a baud mismatch.
    task automatic send_byte(input logic [7:0] b, input logic stop_v, input bit alt, input int nbits);
        logic [9:0] bits;
        int last;
        bits = {stop_v, b, 1'b0};
        last = (nbits >= 8) ? 9 : nbits;
        for (int k = 0; k <= last; k++) begin
            rx = bits[k];
            repeat ((alt && (k % 2 == 1)) ? OVS + 1 : OVS) @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * OVS) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [31:0] bytes_lsb_first, input bit alt);
        for (int i = 0; i < 4; i++) send_byte(bytes_lsb_first[i*8 +: 8], 1'b1, alt, 8);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset = 1'b0;
        en    = 1'b0;
        rx    = 1'b1;
        cycle = 6'd0;
        #2 reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_strobes", {28'd0, wr_en, frame_done, frame_err, busy}, 32'd0);
        chk("reset_wr_addr", wr_addr, 32'h000);
        chk("reset_wr_data", wr_data, 32'h00);
        chk("reset_state", state, ST_IDLE);
        @(posedge clk);
        #1 reset = 1'b0;
        en = 1'b1;
        idle_bits(2);

        // Clean frame, back-to-back bytes, slot 3.
        step_begin();
        cycle = 6'd3;
        send_frame(32'h00FF3CA5, 1'b0);
        idle_bits(3);
        exp_q.push_back({9'h00C, 8'hA5});
        exp_q.push_back({9'h00D, 8'h3C});
        exp_q.push_back({9'h00E, 8'hFF});
        exp_q.push_back({9'h00F, 8'h00});
        check_writes("clean");
        chk("clean_done", done_cnt - done_base, 1);
        chk("clean_err", err_cnt - err_base, 0);
        chk("clean_done_after_write", last_done_cyc - last_wr_cyc, 1);

        // Framing error on byte 2, then a clean frame.
        step_begin();
        cycle = 6'd7;
        send_byte(8'h11, 1'b1, 1'b0, 8);
        send_byte(8'h22, 1'b1, 1'b0, 8);
        send_byte(8'h33, 1'b0, 1'b0, 8);
        idle_bits(3);
        exp_q.push_back({9'h01C, 8'h11});
        exp_q.push_back({9'h01D, 8'h22});
        check_writes("stoperr");
        chk("stoperr_err", err_cnt - err_base, 1);
        chk("stoperr_done", done_cnt - done_base, 0);

        step_begin();
        cycle = 6'd9;
        send_frame(32'hC37E8001, 1'b0);
        idle_bits(3);
        exp_q.push_back({9'h024, 8'h01});
        exp_q.push_back({9'h025, 8'h80});
        exp_q.push_back({9'h026, 8'h7E});
        exp_q.push_back({9'h027, 8'hC3});
        check_writes("recover");
        chk("recover_done", done_cnt - done_base, 1);

        // Inter-byte timeout after byte 1.
        step_begin();
        cycle = 6'd2;
        send_byte(8'h5A, 1'b1, 1'b0, 8);
        send_byte(8'h96, 1'b1, 1'b0, 8);
        idle_bits(6);
        exp_q.push_back({9'h008, 8'h5A});
        exp_q.push_back({9'h009, 8'h96});
        check_writes("timeout");
        chk("timeout_err", err_cnt - err_base, 1);
        chk("timeout_done", done_cnt - done_base, 0);
        chk("timeout_latency", last_err_cyc - last_wr_cyc, 32);

        step_begin();
        cycle = 6'd5;
        send_frame(32'hEFBEADDE, 1'b0);
        idle_bits(3);
        exp_q.push_back({9'h014, 8'hDE});
        exp_q.push_back({9'h015, 8'hAD});
        exp_q.push_back({9'h016, 8'hBE});
        exp_q.push_back({9'h017, 8'hEF});
        check_writes("after_timeout");
        chk("after_timeout_done", done_cnt - done_base, 1);

        // Three-clock glitch in IDLE.
        step_begin();
        rx = 1'b0;
        repeat (3) @(posedge clk);
        #1 rx = 1'b1;
        chk("glitch_busy", busy, 1'b1);
        repeat (12) @(posedge clk);
        #1;
        chk("glitch_state", state, ST_IDLE);
        idle_bits(2);
        check_writes("glitch");
        chk("glitch_pulses", (done_cnt - done_base) + (err_cnt - err_base), 0);

        // Enable dropped during byte 1 data bits.
        step_begin();
        cycle = 6'd1;
        send_byte(8'h44, 1'b1, 1'b0, 8);
        send_byte(8'hA7, 1'b1, 1'b0, 3);
        en = 1'b0;
        rx = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("en_drop_state", state, ST_IDLE);
        chk("en_drop_busy", busy, 1'b0);
        @(posedge clk);
        #1;
        idle_bits(3);
        en = 1'b1;
        idle_bits(3);
        exp_q.push_back({9'h004, 8'h44});
        check_writes("en_drop");
        chk("en_drop_pulses", (done_cnt - done_base) + (err_cnt - err_base), 0);

        // Reset asserted in the middle of byte 1.
        step_begin();
        send_byte(8'h55, 1'b1, 1'b0, 8);
        send_byte(8'hC1, 1'b1, 1'b0, 5);
        reset = 1'b1;
        rx    = 1'b1;
        @(negedge clk);
        chk("midreset_state", state, ST_IDLE);
        chk("midreset_wr_addr", wr_addr, 32'h000);
        chk("midreset_wr_data", wr_data, 32'h00);
        @(posedge clk);
        #1 reset = 1'b0;
        idle_bits(4);
        exp_q.push_back({9'h004, 8'h55});
        check_writes("midreset");
        chk("midreset_pulses", (done_cnt - done_base) + (err_cnt - err_base), 0);

        // Baud mismatch: bit periods alternate 8 and 9 clocks.
        step_begin();
        cycle = 6'h3F;
        send_frame(32'h0FF06996, 1'b1);
        idle_bits(3);
        exp_q.push_back({9'h0FC, 8'h96});
        exp_q.push_back({9'h0FD, 8'h69});
        exp_q.push_back({9'h0FE, 8'hF0});
        exp_q.push_back({9'h0FF, 8'h0F});
        check_writes("baud_skew");
        chk("baud_skew_done", done_cnt - done_base, 1);
        chk("baud_skew_err", err_cnt - err_base, 0);

        chk("strobe_overlap", overlap_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
